// File: rtl/sincos_pkg.sv
// Shared defaults for the sincos NCO channel scheduler and its tag store.
package sincos_pkg;

    localparam int NUM_CH_DEF     = 4;
    localparam int PHASE_BITS_DEF = 47;
    localparam int OUT_BITS_DEF   = 56;
    localparam int TAG_DEPTH_DEF  = 16;

    // Channel ids stay at least one bit wide even for a single channel.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W_DEF = id_width(NUM_CH_DEF);

endpackage

// File: rtl/sincos_tag_fifo.sv
// Synchronous FIFO holding the channel id of each in-flight datapath request.
module sincos_tag_fifo #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign push_ok  = push && (count != CNT_W'(DEPTH));
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; entries are only read after being written, so resetting it buys nothing.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sin_channel_scheduler.sv
// Round-robin scheduler time-sharing one sin_quadratic pipeline across NUM_CH
// phase-accumulator channels, re-tagging each returning result with its channel.
module sin_channel_scheduler
    import sincos_pkg::*;
#(
    parameter  int NUM_CH     = NUM_CH_DEF,
    parameter  int PHASE_BITS = PHASE_BITS_DEF,
    parameter  int OUT_BITS   = OUT_BITS_DEF,
    parameter  int TAG_DEPTH  = TAG_DEPTH_DEF,
    localparam int CH_W       = id_width(NUM_CH),
    localparam int CNT_W      = $clog2(TAG_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [PHASE_BITS-1:0] cfg_freq,
    input  logic                  cfg_clr,
    input  logic [NUM_CH-1:0]     ch_en,
    output logic                  dp_valid_i,
    output logic [PHASE_BITS-1:0] dp_phase,
    input  logic                  dp_valid_o,
    input  logic [OUT_BITS-1:0]   dp_y,
    output logic                  res_valid,
    output logic [CH_W-1:0]       res_ch,
    output logic [OUT_BITS-1:0]   res_y,
    output logic                  err_orphan
);

    logic [PHASE_BITS-1:0] freq [NUM_CH];
    logic [PHASE_BITS-1:0] acc  [NUM_CH];
    logic [CH_W-1:0]       last_grant;
    logic [CH_W-1:0]       grant_ch;
    logic [CH_W:0]         cand;
    logic                  grant_any;
    logic                  grant;
    logic [CNT_W-1:0]      inflight;
    logic                  tag_empty;
    logic [CH_W-1:0]       tag_head;
    logic                  pop;

    // NOTE: every output of this block gets a default up front so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = {1'b0, last_grant} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
            if (!grant_any && ch_en[cand[CH_W-1:0]]) begin
                grant_any = 1'b1;
                grant_ch  = cand[CH_W-1:0];
            end
        end
    end

    // Registered occupancy gates the grant, so a same-cycle pop never frees a slot early.
    assign grant = grant_any && (inflight < CNT_W'(TAG_DEPTH));
    assign pop   = dp_valid_o && !tag_empty;

    sincos_tag_fifo #(
        .WIDTH (CH_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (grant),
        .push_data (grant_ch),
        .pop       (pop),
        .pop_data  (tag_head),
        .empty     (tag_empty),
        .count     (inflight)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                freq[i] <= '0;
                acc[i]  <= '0;
            end
            last_grant <= CH_W'(NUM_CH - 1);
            dp_valid_i <= 1'b0;
            dp_phase   <= '0;
            res_valid  <= 1'b0;
            res_ch     <= '0;
            res_y      <= '0;
            err_orphan <= 1'b0;
        end else begin
            dp_valid_i <= grant;
            res_valid  <= dp_valid_o;
            if (grant) begin
                dp_phase       <= acc[grant_ch];
                acc[grant_ch]  <= acc[grant_ch] + freq[grant_ch];
                last_grant     <= grant_ch;
            end
            // Placed after the increment so a clear wins on the same channel.
            if (cfg_we) begin
                freq[cfg_ch] <= cfg_freq;
                if (cfg_clr) acc[cfg_ch] <= '0;
            end
            if (dp_valid_o) begin
                res_ch <= tag_empty ? '0 : tag_head;
                res_y  <= dp_y;
                if (tag_empty) err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sin_channel_scheduler.sv
// Directed bench for sin_channel_scheduler: the bench plays the sin_quadratic
// datapath and scoreboards every returned result against the expected channel tag.
module tb_sin_channel_scheduler;

    localparam int NUM_CH = 4;
    localparam int PB     = 47;
    localparam int OB     = 56;
    localparam int TD     = 16;
    localparam int CW     = 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CW-1:0]     cfg_ch = '0;
    logic [PB-1:0]     cfg_freq = '0;
    logic              cfg_clr = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              dp_valid_i;
    logic [PB-1:0]     dp_phase;
    logic              dp_valid_o = 1'b0;
    logic [OB-1:0]     dp_y = '0;
    logic              res_valid;
    logic [CW-1:0]     res_ch;
    logic [OB-1:0]     res_y;
    logic              err_orphan;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [OB-1:0] y;
    } res_t;

    res_t          res_q[$];
    logic [CW-1:0] tag_q[$];
    logic [PB-1:0] held = '0;
    logic [PB-1:0] ph;
    logic [PB-1:0] max_ph;
    int            vectors = 0;
    int            miscompares = 0;

    sin_channel_scheduler #(
        .NUM_CH     (NUM_CH),
        .PHASE_BITS (PB),
        .OUT_BITS   (OB),
        .TAG_DEPTH  (TD)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_freq   (cfg_freq),
        .cfg_clr    (cfg_clr),
        .ch_en      (ch_en),
        .dp_valid_i (dp_valid_i),
        .dp_phase   (dp_phase),
        .dp_valid_o (dp_valid_o),
        .dp_y       (dp_y),
        .res_valid  (res_valid),
        .res_ch     (res_ch),
        .res_y      (res_y),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: queue the expected result for a driven dp_valid_o, then check it appears one edge later.
    task automatic tick();
        res_t r;
        logic exp_rv;
        exp_rv = dp_valid_o;
        if (dp_valid_o) begin
            r.y  = dp_y;
            r.ch = '0;
            if (tag_q.size() > 0) r.ch = tag_q.pop_front();
            res_q.push_back(r);
        end
        @(posedge clk);
        #1;
        check("res_valid", 64'(res_valid), 64'(exp_rv));
        if (exp_rv) begin
            r = res_q.pop_front();
            check("res_ch", 64'(res_ch), 64'(r.ch));
            check("res_y", 64'(res_y), 64'(r.y));
        end
    endtask

    task automatic step(input logic v, input logic [CW-1:0] ch, input logic [PB-1:0] exp_ph, input string tag);
        tick();
        check({tag, ".dp_valid_i"}, 64'(dp_valid_i), 64'(v));
        check({tag, ".dp_phase"}, 64'(dp_phase), 64'(exp_ph));
        if (v) begin
            tag_q.push_back(ch);
            held = exp_ph;
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, held, tag);
    endtask

    task automatic cfg_write(input logic [CW-1:0] ch, input logic [PB-1:0] f);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_freq = f;
        idle("cfg");
        cfg_we   = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        dp_valid_o = 1'b1;
        for (int i = 0; i < n; i++) begin
            dp_y = OB'({$urandom(), $urandom()});
            idle(tag);
        end
        dp_valid_o = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check("rst.err_orphan", 64'(err_orphan), 64'(0));
        check("rst.dp_valid_i", 64'(dp_valid_i), 64'(0));
        check("rst.dp_phase", 64'(dp_phase), 64'(0));
        check("rst.res_valid", 64'(res_valid), 64'(0));
        @(posedge clk);
        #1;
        resetn     = 1'b1;
        dp_valid_o = 1'b0;
        ch_en      = '0;
        held       = '0;
        tag_q.delete();
        res_q.delete();
    endtask

    initial begin
        max_ph = '1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.dp_valid_i", 64'(dp_valid_i), 64'(0));
        check("reset.dp_phase", 64'(dp_phase), 64'(0));
        check("reset.res_valid", 64'(res_valid), 64'(0));
        check("reset.res_ch", 64'(res_ch), 64'(0));
        check("reset.res_y", 64'(res_y), 64'(0));
        check("reset.err_orphan", 64'(err_orphan), 64'(0));
        resetn = 1'b1;

        // Two channels, freq 1 and 2: phases 0,0,1,2,2,4 and tags alternate 0,1
        cfg_write(2'd0, PB'(1));
        cfg_write(2'd1, PB'(2));
        ch_en = 4'b0011;
        step(1'b1, 2'd0, PB'(0), "two_ch");
        step(1'b1, 2'd1, PB'(0), "two_ch");
        step(1'b1, 2'd0, PB'(1), "two_ch");
        step(1'b1, 2'd1, PB'(2), "two_ch");
        step(1'b1, 2'd0, PB'(2), "two_ch");
        step(1'b1, 2'd1, PB'(4), "two_ch");
        ch_en = '0;
        drain(6, "two_ch_ret");
        idle("two_ch_idle");

        // All four channels: grants 0,1,2,3,0,1 back to back
        do_reset();
        cfg_write(2'd0, PB'(1));
        cfg_write(2'd1, PB'(2));
        cfg_write(2'd2, PB'(3));
        cfg_write(2'd3, PB'(5));
        ch_en = 4'b1111;
        step(1'b1, 2'd0, PB'(0), "rr");
        step(1'b1, 2'd1, PB'(0), "rr");
        step(1'b1, 2'd2, PB'(0), "rr");
        step(1'b1, 2'd3, PB'(0), "rr");
        step(1'b1, 2'd0, PB'(1), "rr");
        step(1'b1, 2'd1, PB'(2), "rr");
        ch_en = '0;
        drain(4, "rr_ret");

        // Reset with two requests still in flight: their tags are gone,
        // so a returning result is an orphan with res_ch 0, and the flag is sticky
        do_reset();
        dp_valid_o = 1'b1;
        dp_y = OB'(56'h00_abcd_ef01_2345);
        idle("orphan");
        dp_valid_o = 1'b0;
        check("orphan.err_orphan", 64'(err_orphan), 64'(1));
        for (int i = 0; i < 3; i++) begin
            idle("orphan_hold");
            check("orphan_hold.err_orphan", 64'(err_orphan), 64'(1));
        end
        do_reset();

        // Maximal frequency: phases 0, 2^47-1, 2^47-2
        cfg_write(2'd0, max_ph);
        ch_en = 4'b0001;
        step(1'b1, 2'd0, PB'(0), "wrap");
        step(1'b1, 2'd0, max_ph, "wrap");
        step(1'b1, 2'd0, max_ph - PB'(1), "wrap");
        ch_en = '0;
        drain(3, "wrap_ret");

        // No returns: exactly TD grants, then stall until one result frees a slot
        ph = max_ph - PB'(2);
        ch_en = 4'b0001;
        for (int i = 0; i < TD; i++) begin
            step(1'b1, 2'd0, ph, "fill");
            ph = ph - PB'(1);
        end
        for (int i = 0; i < 3; i++) idle("full");
        dp_valid_o = 1'b1;
        dp_y = OB'(56'h12_3456_789a_bcde);
        idle("full_pop");
        dp_valid_o = 1'b0;
        step(1'b1, 2'd0, ph, "refill");
        idle("full_again");
        ch_en = '0;
        drain(TD, "full_ret");
        check("full.err_orphan", 64'(err_orphan), 64'(0));

        // Clear of channel 2 during its own grant: old phase issues, next issue is 0
        do_reset();
        cfg_write(2'd2, PB'(7));
        ch_en = 4'b0100;
        step(1'b1, 2'd2, PB'(0), "clr");
        cfg_we   = 1'b1;
        cfg_clr  = 1'b1;
        cfg_ch   = 2'd2;
        cfg_freq = PB'(7);
        step(1'b1, 2'd2, PB'(7), "clr_grant");
        cfg_we   = 1'b0;
        cfg_clr  = 1'b0;
        step(1'b1, 2'd2, PB'(0), "clr_after");
        step(1'b1, 2'd2, PB'(7), "clr_after");
        ch_en = '0;
        drain(4, "clr_ret");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sin_channel_scheduler.md
SIN_CHANNEL_SCHEDULER -- requirements
Module: sin_channel_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of NCO channels sharing one sin_quadratic pipeline.
REQ-002 SHALL have parameter PHASE_BITS, default 47: phase/frequency word width.
REQ-003 SHALL have parameter OUT_BITS, default 56: result width, matching sin_quadratic y_out.
REQ-004 SHALL have parameter TAG_DEPTH, default 16 (power of 2): maximum in-flight requests.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-007 SHALL have port cfg_we  in  1  configuration write strobe.
REQ-008 SHALL have port cfg_ch  in  clog2(NUM_CH)  target channel of the write.
REQ-009 SHALL have port cfg_freq  in  PHASE_BITS  phase increment written to the channel.
REQ-010 SHALL have port cfg_clr  in  1  with cfg_we, also zero the channel accumulator.
REQ-011 SHALL have port ch_en  in  NUM_CH  per-channel issue enable.
REQ-012 SHALL have port dp_valid_i  out  1  to sin_quadratic valid_i.
REQ-013 SHALL have port dp_phase  out  PHASE_BITS  to sin_quadratic phase.
REQ-014 SHALL have port dp_valid_o  in  1  from sin_quadratic valid_o.
REQ-015 SHALL have port dp_y  in  OUT_BITS  from sin_quadratic y_out.
REQ-016 SHALL have port res_valid  out  1  result strobe; no backpressure.
REQ-017 SHALL have port res_ch  out  clog2(NUM_CH)  channel owning res_y.
REQ-018 SHALL have port res_y  out  OUT_BITS  registered copy of dp_y.
REQ-019 SHALL have port err_orphan  out  1  sticky: dp_valid_o arrived with tag FIFO empty.

Function
REQ-020 SHALL hold per channel a freq register and a phase accumulator, both PHASE_BITS, wrapping mod 2^PHASE_BITS.
REQ-021 SHALL each cycle grant at most one channel: the first enabled channel after last_grant in round-robin order, only when inflight < TAG_DEPTH.
REQ-022 SHALL on grant of ch register dp_valid_i=1, dp_phase=acc[ch], and update acc[ch] <= acc[ch]+freq[ch] at the same edge; otherwise dp_valid_i=0 and dp_phase holds.
REQ-023 SHALL push the granted channel id into the tag FIFO on every grant and set last_grant to it.
REQ-024 SHALL on dp_valid_o pop one tag and register res_valid=1, res_ch=tag, res_y=dp_y one cycle later.
REQ-025 SHALL leave inflight unchanged on simultaneous push and pop; with inflight==TAG_DEPTH a same-cycle pop SHALL NOT enable a same-cycle grant.
REQ-026 SHALL on dp_valid_o with tag FIFO empty set err_orphan, pulse res_valid with res_ch=0, and not change inflight.
REQ-027 SHALL on cfg_we write freq[cfg_ch] at the next edge; with cfg_clr, acc[cfg_ch] <= 0, overriding a same-cycle increment.
REQ-028 SHALL let a same-cycle grant of cfg_ch issue the pre-write acc value.
REQ-029 SHALL deassert no in-flight state when ch_en drops; outstanding results still return tagged.

Reset
REQ-030 SHALL on resetn low clear asynchronously: dp_valid_i, dp_phase, res_valid, res_ch, res_y, err_orphan, all freq/acc, tag pointers, inflight; last_grant=NUM_CH-1.
REQ-031 SHALL, after reset mid-operation, discard all in-flight tags; results of requests issued before reset are not tracked.

Structure
REQ-032 SHALL place NUM_CH, PHASE_BITS, OUT_BITS, TAG_DEPTH defaults and the channel-id width in the shared sincos package.
REQ-033 SHALL implement the tag store as one sub-module sincos_tag_fifo (sync FIFO, TAG_DEPTH entries, count output).

Verification
REQ-034 SHALL cover: reset, freq[0]=1, freq[1]=2, ch_en=0011 -> dp_phase sequence 0,0,1,2,2,4; res_ch alternates 0,1.
REQ-035 SHALL cover: ch_en=1111, all freqs nonzero -> grants 0,1,2,3,0 with no cycle skipped.
REQ-036 SHALL cover: freq=2^47-1, acc starts 0 -> second issue phase 2^47-1, third 2^47-2 (wrap).
REQ-037 SHALL cover: dp_valid_o held 0 -> exactly 16 grants then dp_valid_i stays 0; one dp_valid_o -> one grant one cycle later.
REQ-038 SHALL cover: cfg_we+cfg_clr on ch 2 during its grant -> issued phase old acc, next issue of ch 2 phase 0.
REQ-039 SHALL cover: dp_valid_o with no request issued -> err_orphan=1 and held until resetn low.
